// File: rtl/puf_challenge_driver_if.sv
// PUF-side bus (challenge, launch pulse, raw response) and the result stream.
// Result stream handshake: a transfer happens on a rising clk edge where
// resp_valid && resp_ready. Once resp_valid is raised, it and every resp_*
// field hold unchanged until that edge. resp_valid never depends on resp_ready.
interface puf_challenge_driver_if #(
    parameter int CH_W   = 8,
    parameter int RESP_W = 7
);
    logic [CH_W-1:0]   puf_challenge;
    logic              puf_pulse;
    logic [RESP_W-1:0] puf_response;
    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] resp_data;
    logic [CH_W-1:0]   resp_challenge;
    logic [RESP_W-1:0] resp_stable;

    modport master (
        output puf_challenge, puf_pulse,
        input  puf_response,
        output resp_valid, resp_data, resp_challenge, resp_stable,
        input  resp_ready
    );

    modport slave (
        input  puf_challenge, puf_pulse,
        output puf_response,
        input  resp_valid, resp_data, resp_challenge, resp_stable,
        output resp_ready
    );
endinterface

// File: rtl/puf_challenge_driver.sv
// Arbiter-PUF initiator: drives challenges, fires the launch pulse, samples the
// synchronised response NVOTE times per challenge, majority-votes each bit and
// streams {challenge, voted response, stability mask} to the consumer.
module puf_challenge_driver #(
    parameter int              CH_W      = 8,
    parameter int              RESP_W    = 7,
    parameter int              SETTLE    = 4,
    parameter int              NVOTE     = 5,
    parameter logic [CH_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [CH_W-1:0] chal_in,
    input  logic [7:0]      num_chal,
    output logic            busy,
    output logic            done,
    output logic [2:0]      dbg_state,
    puf_challenge_driver_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOW     = 3'd1;
    localparam logic [2:0] S_HIGH    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int CNT_W = $clog2(NVOTE + 1);
    localparam int PH_W  = $clog2(SETTLE) + 1;

    logic [2:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  vote_q, vote_d;
    logic [CNT_W-1:0]  ones_q [RESP_W];
    logic [CNT_W-1:0]  ones_d [RESP_W];
    logic [CH_W-1:0]   chal_q, chal_d;
    logic              mode_q, mode_d;
    logic [8:0]        remain_q, remain_d;
    logic              resp_valid_q, resp_valid_d;
    logic [RESP_W-1:0] resp_data_q, resp_data_d;
    logic [RESP_W-1:0] resp_stable_q, resp_stable_d;
    logic [CH_W-1:0]   resp_chal_q, resp_chal_d;
    logic [RESP_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CH_W-1:0]   chal_next;

    // Next challenge: increment (wraps) or the 8-bit Fibonacci LFSR step.
    always_comb begin
        if (mode_q) begin
            chal_next = {chal_q[CH_W-2:0], chal_q[7] ^ chal_q[5] ^ chal_q[4] ^ chal_q[3]};
        end else begin
            chal_next = chal_q + CH_W'(1);
        end
    end

    // Sequencer: LOW(2) -> HIGH(SETTLE) -> CAPTURE(1), NVOTE times, then OUTPUT.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        vote_d        = vote_q;
        ones_d        = ones_q;
        chal_d        = chal_q;
        mode_d        = mode_q;
        remain_d      = remain_q;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        resp_stable_d = resp_stable_q;
        resp_chal_d   = resp_chal_q;
        sync1_d       = bus.puf_response;
        sync2_d       = sync1_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    chal_d   = (mode && chal_in == '0) ? LFSR_SEED : chal_in;
                    remain_d = (num_chal == 8'd0) ? 9'd256 : {1'b0, num_chal};
                    vote_d   = '0;
                    phase_d  = '0;
                    for (int b = 0; b < RESP_W; b++) ones_d[b] = '0;
                    state_d  = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == PH_W'(1)) begin
                    phase_d = '0;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_q == PH_W'(SETTLE - 1)) begin
                    phase_d = '0;
                    state_d = S_CAPTURE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_CAPTURE: begin
                for (int b = 0; b < RESP_W; b++) begin
                    ones_d[b] = ones_q[b] + CNT_W'(sync2_q[b]);
                end
                vote_d = vote_q + CNT_W'(1);
                if (vote_d == CNT_W'(NVOTE)) begin
                    // Result is registered on OUTPUT entry from the updated counts.
                    for (int b = 0; b < RESP_W; b++) begin
                        resp_data_d[b]   = (ones_d[b] > CNT_W'(NVOTE / 2));
                        resp_stable_d[b] = (ones_d[b] == '0) || (ones_d[b] == CNT_W'(NVOTE));
                    end
                    resp_chal_d  = chal_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_OUTPUT;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_OUTPUT: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    remain_d     = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        state_d = S_DONE;
                    end else begin
                        vote_d  = '0;
                        for (int b = 0; b < RESP_W; b++) ones_d[b] = '0;
                        chal_d  = chal_next;
                        state_d = S_LOW;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, result registers and response synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            vote_q        <= '0;
            for (int b = 0; b < RESP_W; b++) ones_q[b] <= '0;
            chal_q        <= '0;
            mode_q        <= 1'b0;
            remain_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_stable_q <= '0;
            resp_chal_q   <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            vote_q        <= vote_d;
            ones_q        <= ones_d;
            chal_q        <= chal_d;
            mode_q        <= mode_d;
            remain_q      <= remain_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_stable_q <= resp_stable_d;
            resp_chal_q   <= resp_chal_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
        end
    end

    // Pulse decodes straight from state so reset drops it without a clock.
    always_comb begin
        bus.puf_pulse      = (state_q == S_HIGH) || (state_q == S_CAPTURE);
        bus.puf_challenge  = chal_q;
        bus.resp_valid     = resp_valid_q;
        bus.resp_data      = resp_data_q;
        bus.resp_stable    = resp_stable_q;
        bus.resp_challenge = resp_chal_q;
        busy               = (state_q != S_IDLE) && (state_q != S_DONE);
        done               = (state_q == S_DONE);
        dbg_state          = state_q;
    end
endmodule
